// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the req/addr_ok/data_ok handshake with at most
// one request outstanding, buffers one instruction for decode and handles redirects.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst,
  output logic        fetch_adel,
  output logic        busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_wait_cnt,
  output logic [31:0] perf_cancel_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_CANCEL = 2'd2,
    S_EXC    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] fetch_inst_q, fetch_inst_d;
  logic        fetch_adel_q, fetch_adel_d;

  logic        buf_free;
  logic        pc_aligned;
  logic        req_fire;

  // The buffer can take a new entry if it is empty or decode drains it this cycle.
  assign buf_free   = ~fetch_valid_q | ~stall_in;
  assign pc_aligned = (pc_q[1:0] == 2'b00);

  assign inst_req  = ~rst & (state_q == S_REQ) & buf_free & pc_aligned & ~redirect_valid;
  assign inst_addr = pc_q;
  assign req_fire  = inst_req & inst_addr_ok;

  assign busy        = (state_q == S_WAIT) | (state_q == S_CANCEL);
  assign fetch_valid = fetch_valid_q;
  assign fetch_pc    = fetch_pc_q;
  assign fetch_inst  = fetch_inst_q;
  assign fetch_adel  = fetch_adel_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q & stall_in;
    fetch_pc_d    = fetch_pc_q;
    fetch_inst_d  = fetch_inst_q;
    fetch_adel_d  = fetch_adel_q;

    if (redirect_valid) begin
      pc_d          = redirect_pc;
      fetch_valid_d = 1'b0;
      unique case (state_q)
        S_REQ:    state_d = S_REQ;
        S_WAIT:   state_d = inst_data_ok ? S_REQ : S_CANCEL;
        S_CANCEL: state_d = inst_data_ok ? S_REQ : S_CANCEL;
        S_EXC:    state_d = S_REQ;
        default:  state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_d = S_WAIT;
          end else if (~pc_aligned && buf_free) begin
            // Misaligned PC becomes a buffered fault entry; no SRAM access is made.
            fetch_valid_d = 1'b1;
            fetch_pc_d    = pc_q;
            fetch_inst_d  = 32'h0;
            fetch_adel_d  = 1'b1;
            state_d       = S_EXC;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            fetch_valid_d = 1'b1;
            fetch_pc_d    = pc_q;
            fetch_inst_d  = inst_rdata;
            fetch_adel_d  = 1'b0;
            pc_d          = pc_q + 32'd4;
            state_d       = S_REQ;
          end
        end
        S_CANCEL: begin
          if (inst_data_ok) begin
            state_d = S_REQ;
          end
        end
        S_EXC:   state_d = S_EXC;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_ADDR;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= RESET_ADDR;
      fetch_inst_q  <= 32'h0;
      fetch_adel_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_inst_q  <= fetch_inst_d;
      fetch_adel_q  <= fetch_adel_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_wait_cnt_q, perf_wait_cnt_d;
  logic [31:0] perf_cancel_cnt_q, perf_cancel_cnt_d;

  always_comb begin
    perf_wait_cnt_d   = perf_wait_cnt_q;
    perf_cancel_cnt_d = perf_cancel_cnt_q;
    if (busy) begin
      perf_wait_cnt_d = perf_wait_cnt_q + 32'd1;
    end
    // Count transitions into S_CANCEL, not cycles spent there.
    if ((state_d == S_CANCEL) && (state_q != S_CANCEL)) begin
      perf_cancel_cnt_d = perf_cancel_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_wait_cnt_q   <= 32'h0;
      perf_cancel_cnt_q <= 32'h0;
    end else begin
      perf_wait_cnt_q   <= perf_wait_cnt_d;
      perf_cancel_cnt_q <= perf_cancel_cnt_d;
    end
  end

  assign perf_wait_cnt   = perf_wait_cnt_q;
  assign perf_cancel_cnt = perf_cancel_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: small SRAM responder stepped by the stimulus
// sequence, immediate assertions on hand-computed expected values.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_adel;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // SRAM responder state
  int          sram_lat;
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall_in      (stall_in),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_inst    (fetch_inst),
    .fetch_adel    (fetch_adel),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample the handshake at negedge, pass posedge, then update the SRAM.
  // Returned data is the bitwise inverse of the address.
  task automatic tick();
    logic acc;
    logic resp;
    logic [31:0] acc_addr;
    @(negedge clk);
    acc      = inst_req & inst_addr_ok;
    acc_addr = inst_addr;
    resp     = inst_data_ok;
    @(posedge clk);
    #1;
    if (rst) begin
      pend         = 1'b0;
      inst_data_ok = 1'b0;
    end else begin
      if (resp) inst_data_ok = 1'b0;
      if (acc) begin
        pend      = 1'b1;
        pend_cnt  = sram_lat;
        pend_addr = acc_addr;
      end
      if (pend) begin
        if (pend_cnt <= 1) begin
          inst_data_ok = 1'b1;
          inst_rdata   = ~pend_addr;
          pend         = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
    end
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    stall_in       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_addr_ok   = 1'b1;
    inst_data_ok   = 1'b0;
    inst_rdata     = 32'h0;
    sram_lat       = 1;
    pend           = 1'b0;
    pend_cnt       = 0;
    pend_addr      = 32'h0;

    tick();
    tick();
    check("rst_valid", {31'b0, fetch_valid}, 32'h0);
    check("rst_pc",    fetch_pc,             32'hbfc00000);
    check("rst_inst",  fetch_inst,           32'h0);
    check("rst_adel",  {31'b0, fetch_adel},  32'h0);
    check("rst_req",   {31'b0, inst_req},    32'h0);
    check("rst_busy",  {31'b0, busy},        32'h0);

    // 1: sequential fetch
    rst = 1'b0;
    #1;
    check("t1_req0",  {31'b0, inst_req}, 32'h1);
    check("t1_addr0", inst_addr,         32'hbfc00000);
    tick();
    check("t1_busy",  {31'b0, busy},     32'h1);
    check("t1_noreq", {31'b0, inst_req}, 32'h0);
    tick();
    check("t1_v0",    {31'b0, fetch_valid}, 32'h1);
    check("t1_pc0",   fetch_pc,             32'hbfc00000);
    check("t1_inst0", fetch_inst,           32'h403fffff);
    check("t1_addr1", inst_addr,            32'hbfc00004);
    check("t1_req1",  {31'b0, inst_req},    32'h1);
    tick();
    check("t1_drain", {31'b0, fetch_valid}, 32'h0);
    tick();
    check("t1_v1",    {31'b0, fetch_valid}, 32'h1);
    check("t1_pc1",   fetch_pc,             32'hbfc00004);
    check("t1_inst1", fetch_inst,           32'h403ffffb);

    // 2: decode stall with a full buffer
    stall_in = 1'b1;
    #1;
    check("t2_req_off", {31'b0, inst_req}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_v",    {31'b0, fetch_valid}, 32'h1);
      check("t2_hold_pc",   fetch_pc,             32'hbfc00004);
      check("t2_hold_inst", fetch_inst,           32'h403ffffb);
      check("t2_hold_req",  {31'b0, inst_req},    32'h0);
    end
    stall_in = 1'b0;
    #1;
    check("t2_req_on", {31'b0, inst_req}, 32'h1);
    check("t2_addr",   inst_addr,         32'hbfc00008);
    tick();
    tick();
    check("t1_v2",    {31'b0, fetch_valid}, 32'h1);
    check("t1_pc2",   fetch_pc,             32'hbfc00008);
    check("t1_inst2", fetch_inst,           32'h403ffff7);

    // 3: redirect while waiting; late response must be dropped
    sram_lat = 4;
    tick();
    check("t3_wait", {31'b0, busy}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80001000;
    #1;
    check("t3_req_off", {31'b0, inst_req}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t3_busy1", {31'b0, busy},     32'h1);
    check("t3_noreq", {31'b0, inst_req}, 32'h0);
    tick();
    check("t3_busy2", {31'b0, busy}, 32'h1);
    tick();
    check("t3_dok",   {31'b0, inst_data_ok}, 32'h1);
    check("t3_busy3", {31'b0, busy},         32'h1);
    tick();
    check("t3_drop",  {31'b0, fetch_valid}, 32'h0);
    check("t3_idle",  {31'b0, busy},        32'h0);
    check("t3_req",   {31'b0, inst_req},    32'h1);
    check("t3_addr",  inst_addr,            32'h80001000);
    sram_lat = 1;
    tick();
    tick();
    check("t3_v",    {31'b0, fetch_valid}, 32'h1);
    check("t3_pc",   fetch_pc,             32'h80001000);
    check("t3_inst", fetch_inst,           32'h7fffefff);

    // 4: misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80002002;
    #1;
    check("t4_req_forced", {31'b0, inst_req}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t4_flush", {31'b0, fetch_valid}, 32'h0);
    check("t4_noreq", {31'b0, inst_req},    32'h0);
    tick();
    check("t4_v",     {31'b0, fetch_valid}, 32'h1);
    check("t4_adel",  {31'b0, fetch_adel},  32'h1);
    check("t4_pc",    fetch_pc,             32'h80002002);
    check("t4_inst",  fetch_inst,           32'h0);
    check("t4_noreq2",{31'b0, inst_req},    32'h0);
    tick();
    check("t4_exc_v",   {31'b0, fetch_valid}, 32'h0);
    check("t4_exc_req", {31'b0, inst_req},    32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80003000;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t4_resume_req",  {31'b0, inst_req}, 32'h1);
    check("t4_resume_addr", inst_addr,         32'h80003000);
    tick();
    tick();
    check("t4_v2",    {31'b0, fetch_valid}, 32'h1);
    check("t4_adel2", {31'b0, fetch_adel},  32'h0);
    check("t4_inst2", fetch_inst,           32'h7fffcfff);

    // 5a: redirect in the same cycle as data_ok
    tick();
    check("t5_dok", {31'b0, inst_data_ok}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80004000;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t5a_v",    {31'b0, fetch_valid}, 32'h0);
    check("t5a_busy", {31'b0, busy},        32'h0);
    check("t5a_req",  {31'b0, inst_req},    32'h1);
    check("t5a_addr", inst_addr,            32'h80004000);
    tick();
    tick();
    check("t5a_pc",   fetch_pc,   32'h80004000);
    check("t5a_inst", fetch_inst, 32'h7fffbfff);

    // 5b: redirect while stalled with a full buffer
    stall_in = 1'b1;
    tick();
    check("t5b_full", {31'b0, fetch_valid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80005000;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t5b_flush", {31'b0, fetch_valid}, 32'h0);
    check("t5b_req",   {31'b0, inst_req},    32'h1);
    check("t5b_addr",  inst_addr,            32'h80005000);
    stall_in = 1'b0;
    tick();
    tick();
    check("t5b_pc",   fetch_pc,   32'h80005000);
    check("t5b_inst", fetch_inst, 32'h7fffafff);

    // 6: asynchronous reset while waiting
    tick();
    check("t6_busy", {31'b0, busy}, 32'h1);
    #2;
    rst          = 1'b1;
    inst_data_ok = 1'b0;
    pend         = 1'b0;
    #1;
    check("t6_req",  {31'b0, inst_req},    32'h0);
    check("t6_busy0",{31'b0, busy},        32'h0);
    check("t6_v",    {31'b0, fetch_valid}, 32'h0);
    check("t6_pc",   fetch_pc,             32'hbfc00000);
    check("t6_inst", fetch_inst,           32'h0);
    check("t6_adel", {31'b0, fetch_adel},  32'h0);
    check("t6_addr", inst_addr,            32'hbfc00000);
    tick();
    rst = 1'b0;
    #1;
    check("t6_req1",  {31'b0, inst_req}, 32'h1);
    check("t6_addr1", inst_addr,         32'hbfc00000);
    tick();
    tick();
    check("t6_v1",    {31'b0, fetch_valid}, 32'h1);
    check("t6_inst1", fetch_inst,           32'h403fffff);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
